shift_frame_ctrl: RTL
=====================

# shift_frame_ctrl

Sequencing controller for the serial-to-parallel `shift_reg` datapath. It gates the register's active-low shift enable with incoming bit strobes and counts exactly NDATA bits per frame. It then captures the parallel word into an output holding register and offers it downstream over a valid/ready handshake. It sits between the serial front end (bit strobe source) and the frame consumer.

## Interface
- `NDATA`, 128: frame length in bits; must match the driven `shift_reg`.
- `TIMEOUT`, 1024: idle cycles allowed between bits mid-frame. Used only with the timeout feature; must be ≥ 1.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that opens a frame; ignored unless in IDLE.
- `bit_vld` in 1: strobe; `bit_in` is valid this cycle.
- `bit_in` in 1: serial data bit.
- `sr_din` out 1: data to `shift_reg.din`; equals `bit_in`, combinational.
- `sr_ena` out 1: to `shift_reg.ena`, active-low. Driven 0 only when state is SHIFT and `bit_vld` is 1; combinational.
- `sr_dout` in NDATA: parallel output of `shift_reg`.
- `frame` out NDATA: holding register; reset value 0.
- `frame_vld` out 1: `frame` holds an unconsumed word; reset value 0.
- `frame_rdy` in 1: consumer accepts `frame` when `frame_vld && frame_rdy`.
- `busy` out 1: high in SHIFT or CAPT; reset value 0.
- `ovf` out 1: one-cycle pulse when a completed frame is dropped; reset value 0.
- `abort` out 1: one-cycle timeout pulse; present only with the timeout feature; reset value 0.

## Operation
- States: IDLE, SHIFT, CAPT. Reset state is IDLE, with bit counter = 0.
- IDLE → SHIFT on `start`. In that cycle the counter clears and `bit_vld` is ignored. The first counted bit is in the cycle after `start`.
- SHIFT: each `bit_vld` cycle shifts one bit and increments the counter. Counter width is `$clog2(NDATA)`; it never wraps within a frame.
- When `bit_vld` is 1 and counter = NDATA-1, the state goes to CAPT and the counter clears.
- CAPT lasts one cycle, then the state returns to IDLE. CAPT always exits to IDLE; a new frame needs a new `start`.
- In CAPT, the slot is free if `frame_vld` is 0, or if `frame_vld && frame_rdy`. If free: `frame` ← `sr_dout` and `frame_vld` ← 1.
- In CAPT with `frame_vld` = 1 and `frame_rdy` = 0: the new word is discarded, `frame` is unchanged, and `ovf` pulses in the next cycle.
- Outside CAPT, a handshake (`frame_vld && frame_rdy`) clears `frame_vld` next cycle. `frame` keeps its value.
- `start` in SHIFT or CAPT is ignored and is not queued.
- Reset mid-frame: the state returns to IDLE and the counter to 0. `frame_vld`, `frame`, `ovf` and `abort` return to 0. `sr_ena` is 1 while `rst` is high. The partial contents of `shift_reg` are left as-is; they are overwritten by the next full frame.

## Timing
- `sr_ena` and `sr_din` follow `bit_vld` and `bit_in` combinationally in the same cycle.
- The last bit is shifted at edge E, so `sr_dout` holds the full frame after E. CAPT is the cycle after E. `frame` and `frame_vld` update at edge E+1.
- Latency: `frame_vld` is first seen high 2 cycles after the last `bit_vld` cycle.
- Bit order: the first bit received ends in `frame[NDATA-1]`; the last bit in `frame[0]`.
- Back-to-back `bit_vld` at full rate is supported. The minimum frame period is NDATA+2 cycles, including `start`.

## Configuration
- Macro `SHIFT_FRAME_CTRL_TIMEOUT_EN`.
- When defined:
  - An idle counter runs in SHIFT. It clears on every `bit_vld` and on entry to SHIFT.
  - When it reaches TIMEOUT with no bit, the state goes to IDLE and the bit counter clears.
  - `abort` pulses for one cycle and `frame` is untouched.
- When undefined: SHIFT waits indefinitely. The `abort` port and the idle counter do not exist.

## Structure
- Shared package `shift_frame_pkg` holds:
  - the state encoding constants (IDLE=0, SHIFT=1, CAPT=2, 2-bit);
  - the counter-width function/constant derived from NDATA.
- One sub-module: `frame_bit_cnt`, a clear/increment counter with a terminal-count output at NDATA-1. It is reused for the idle counter (terminal at TIMEOUT) when the macro is defined.
- `shift_reg` is instantiated beside this block by the top level, not inside it.

## Test plan
- NDATA=8: `start`, then 8 consecutive `bit_vld` with bits 1,0,1,1,0,0,1,0 and `frame_rdy`=1.
  - Expect `frame`=8'hB2 and `frame_vld` high 2 cycles after the 8th bit.
  - Expect `sr_ena`=0 on exactly 8 cycles.
- Bits with gaps (`bit_vld` every 3rd cycle), same data → `frame`=8'hB2; `busy` held through the gaps.
- Frame 1 = 8'hB2 held with `frame_rdy`=0, then frame 2 = 8'h5A completes → `ovf` pulses once and `frame` stays 8'hB2.
  - Then `frame_rdy`=1 → `frame_vld` drops the next cycle.
- `rst` asserted after 5 bits → the next cycle shows IDLE, `busy`=0, `frame_vld`=0.
  - A fresh 8-bit frame of 8'hFF then yields exactly 8'hFF.
- `start` together with `bit_vld` (bit 1), then 8 bits of 0 → `frame`=8'h00. Also, a `start` pulse mid-frame does not restart the count.
- With `SHIFT_FRAME_CTRL_TIMEOUT_EN`, TIMEOUT=4: 3 bits, then a 4-cycle gap → `abort` pulses, the state returns to IDLE, `frame_vld` stays 0.

Source files
------------

// File: rtl/shift_frame_pkg.sv
// Shared definitions for the shift_frame_ctrl sequencer: state encoding and
// the counter-width helper used to size the bit and idle counters.
package shift_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CAPT  = 2'd2
    } state_e;

    // Width needed to count 0..n-1; never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_bit_cnt.sv
// Clear/increment counter with a terminal-count flag at TERM.
// Used for the frame bit counter and, when enabled, the mid-frame idle counter.
module frame_bit_cnt #(
    parameter int WIDTH = 7,
    parameter int TERM  = 127
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Clear wins over increment so a terminal bit can restart the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == WIDTH'(TERM));

endmodule

// File: rtl/shift_frame_ctrl.sv
// Sequencer for an external serial-to-parallel shift_reg: gates its active-low
// enable with bit strobes, counts NDATA bits, captures the parallel word into
// a holding register and offers it over valid/ready.
// Optional mid-frame timeout: define SHIFT_FRAME_CTRL_TIMEOUT_EN.
module shift_frame_ctrl
    import shift_frame_pkg::*;
#(
    parameter int NDATA   = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic             sr_din,
    output logic             sr_ena,
    input  logic [NDATA-1:0] sr_dout,
    output logic [NDATA-1:0] frame,
    output logic             frame_vld,
    input  logic             frame_rdy,
    output logic             busy,
`ifdef SHIFT_FRAME_CTRL_TIMEOUT_EN
    output logic             abort,
`endif
    output logic             ovf
);

    localparam int CNT_W = cnt_width(NDATA);

    state_e           state_q, state_d;
    logic [NDATA-1:0] frame_q, frame_d;
    logic             frame_vld_q, frame_vld_d;
    logic             ovf_q, ovf_d;
    logic             bit_clr, bit_inc, bit_tc;
    logic             timeout;

    // TIMEOUT only matters with the timeout feature; a non-positive value has
    // no meaning, and this empty branch keeps the parameter referenced in
    // both builds.
    if (TIMEOUT < 1) begin : g_timeout_out_of_range
    end

    frame_bit_cnt #(
        .WIDTH (CNT_W),
        .TERM  (NDATA - 1)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bit_clr),
        .inc (bit_inc),
        .tc  (bit_tc)
    );

`ifdef SHIFT_FRAME_CTRL_TIMEOUT_EN
    logic abort_q, abort_d;
    logic idle_clr, idle_inc, idle_tc;

    // Idle counter runs only while waiting for a bit in SHIFT; any bit or
    // leaving SHIFT restarts it, so it is already zero on entry to SHIFT.
    assign idle_inc = (state_q == ST_SHIFT) && !bit_vld;
    assign idle_clr = !idle_inc;

    frame_bit_cnt #(
        .WIDTH (cnt_width(TIMEOUT)),
        .TERM  (TIMEOUT - 1)
    ) u_idle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (idle_clr),
        .inc (idle_inc),
        .tc  (idle_tc)
    );

    // Terminal count plus one more idle cycle makes TIMEOUT bitless cycles.
    assign timeout = idle_inc && idle_tc;
    assign abort_d = timeout;
    assign abort   = abort_q;

    // Abort pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and bit-counter control.
    always_comb begin
        state_d = state_q;
        bit_clr = 1'b0;
        bit_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    bit_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_vld) begin
                    if (bit_tc) begin
                        state_d = ST_CAPT;
                        bit_clr = 1'b1;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    bit_clr = 1'b1;
                end
            end
            ST_CAPT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                bit_clr = 1'b1;
            end
        endcase
    end

    // Holding register: load on a free slot in CAPT, else drop and flag
    // overflow; outside CAPT a handshake simply empties the slot.
    always_comb begin
        frame_d     = frame_q;
        frame_vld_d = frame_vld_q;
        ovf_d       = 1'b0;
        if (state_q == ST_CAPT) begin
            if (!frame_vld_q || frame_rdy) begin
                frame_d     = sr_dout;
                frame_vld_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (frame_vld_q && frame_rdy) begin
            frame_vld_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            frame_vld_q <= frame_vld_d;
            ovf_q       <= ovf_d;
        end
    end

    // Shift enable is forced inactive during reset so shift_reg holds.
    assign sr_din    = bit_in;
    assign sr_ena    = !((state_q == ST_SHIFT) && bit_vld && !rst);
    assign frame     = frame_q;
    assign frame_vld = frame_vld_q;
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_CAPT);
    assign ovf       = ovf_q;

endmodule
